// File: rtl/lfm_burst_phase_accum.sv
// -----------------------------------------------------------------------------
// lfm_burst_phase_accum
//
// Generates sine-ROM phase addresses for a burst of NUM_OF_IMP pulses. Each
// pulse starts at phase 0 with frequency word FTW_START. The word is then
// stepped per sample according to MODE (CW, up, down or triangle). Between
// pulses, zero-address gap samples fill out the period. A burst is requested
// with SIGN_START_GEN, acknowledged with SIGN_START_CALC, started by
// OUT_REG_READY, and its last sample is flagged with SIGN_STOP_CALC.
//
// Ports:
//   CLK             system clock
//   RESET_N         asynchronous active-low reset
//   SIGN_START_GEN  burst request (sampled in IDLE only)
//   ABORT           end a running burst after the current sample
//   OUT_REG_READY   downstream ready, starts sample generation
//   MODE            0 CW, 1 up-chirp, 2 down-chirp, 3 triangle
//   FTW_START       initial frequency tuning word
//   FTW_STEP        per-sample frequency step magnitude
//   IMP_SAMPLES     samples per pulse
//   PERIOD_SAMPLES  samples per pulse period (pulse + gap)
//   NUM_OF_IMP      pulses per burst
//   ROM_ADDRESS     phase address (0 when not valid / in gap)
//   ADDR_VALID      ROM_ADDRESS carries a sample
//   SIGN_START_CALC burst accepted, waiting for OUT_REG_READY
//   SIGN_STOP_CALC  flags the final sample of the burst
//   NUM_OF_SAMPLES  total burst length of the last accepted burst
//   BUSY            block is not idle
//   CFG_ERR         one-cycle pulse on a rejected request
//
// All outputs are registered. Outputs for the sample computed in a PULSE/GAP
// state cycle appear on the following cycle. Because of this, ABORT sampled
// in a PULSE/GAP cycle makes that cycle's sample the last one.
// -----------------------------------------------------------------------------
module lfm_burst_phase_accum #(
  parameter int PHASE_W = 32,
  parameter int FREQ_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 28,
  parameter int NIMP_W  = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              SIGN_START_GEN,
  input  logic              ABORT,
  input  logic              OUT_REG_READY,
  input  logic [1:0]        MODE,
  input  logic [FREQ_W-1:0] FTW_START,
  input  logic [FREQ_W-1:0] FTW_STEP,
  input  logic [CNT_W-1:0]  IMP_SAMPLES,
  input  logic [CNT_W-1:0]  PERIOD_SAMPLES,
  input  logic [NIMP_W-1:0] NUM_OF_IMP,
  output logic [ADDR_W-1:0] ROM_ADDRESS,
  output logic              ADDR_VALID,
  output logic              SIGN_START_CALC,
  output logic              SIGN_STOP_CALC,
  output logic [31:0]       NUM_OF_SAMPLES,
  output logic              BUSY,
  output logic              CFG_ERR
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, PULSE, GAP, DONE} state_t;

  state_t             state_reg, state_next;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic [FREQ_W-1:0]  freq_reg, freq_next;
  logic [CNT_W-1:0]   samp_cnt_reg, samp_cnt_next;   // index in pulse or gap
  logic [NIMP_W-1:0]  pulse_cnt_reg, pulse_cnt_next;

  // Configuration latched on acceptance
  logic [1:0]         mode_reg, mode_next;
  logic [FREQ_W-1:0]  ftw_start_reg, ftw_start_next;
  logic [FREQ_W-1:0]  ftw_step_reg, ftw_step_next;
  logic [CNT_W-1:0]   imp_reg, imp_next;
  logic [CNT_W-1:0]   period_reg, period_next;
  logic [NIMP_W-1:0]  nimp_reg, nimp_next;

  // Output registers
  logic [ADDR_W-1:0]  rom_addr_reg, rom_addr_next;
  logic               addr_valid_reg, addr_valid_next;
  logic               start_calc_reg, start_calc_next;
  logic               stop_calc_reg, stop_calc_next;
  logic [31:0]        num_samples_reg, num_samples_next;
  logic               busy_reg, busy_next;
  logic               cfg_err_reg, cfg_err_next;

  logic               cfg_invalid;
  logic [31:0]        burst_len;
  logic               last_samp, last_gap, last_pulse, has_gap;
  logic [FREQ_W-1:0]  freq_stepped;

  assign cfg_invalid = (IMP_SAMPLES == '0) || (NUM_OF_IMP == '0) ||
                       (PERIOD_SAMPLES < IMP_SAMPLES);
  assign burst_len   = 32'(NUM_OF_IMP - NIMP_W'(1)) * 32'(PERIOD_SAMPLES) +
                       32'(IMP_SAMPLES);

  assign last_samp  = (samp_cnt_reg == imp_reg - CNT_W'(1));
  assign last_gap   = (samp_cnt_reg == period_reg - imp_reg - CNT_W'(1));
  assign last_pulse = (pulse_cnt_reg == nimp_reg - NIMP_W'(1));
  assign has_gap    = (period_reg != imp_reg);

  // Frequency word for the next sample; wraps freely in both directions.
  always_comb begin
    freq_stepped = freq_reg;
    case (mode_reg)
      2'd1:    freq_stepped = freq_reg + ftw_step_reg;
      2'd2:    freq_stepped = freq_reg - ftw_step_reg;
      2'd3:    freq_stepped = (samp_cnt_reg < (imp_reg >> 1)) ?
                              freq_reg + ftw_step_reg : freq_reg - ftw_step_reg;
      default: freq_stepped = freq_reg;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    phase_next       = phase_reg;
    freq_next        = freq_reg;
    samp_cnt_next    = samp_cnt_reg;
    pulse_cnt_next   = pulse_cnt_reg;
    mode_next        = mode_reg;
    ftw_start_next   = ftw_start_reg;
    ftw_step_next    = ftw_step_reg;
    imp_next         = imp_reg;
    period_next      = period_reg;
    nimp_next        = nimp_reg;
    rom_addr_next    = '0;
    addr_valid_next  = 1'b0;
    start_calc_next  = start_calc_reg;
    stop_calc_next   = 1'b0;
    num_samples_next = num_samples_reg;
    cfg_err_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (SIGN_START_GEN) begin
          if (cfg_invalid) begin
            cfg_err_next = 1'b1;
          end else begin
            mode_next        = MODE;
            ftw_start_next   = FTW_START;
            ftw_step_next    = FTW_STEP;
            imp_next         = IMP_SAMPLES;
            period_next      = PERIOD_SAMPLES;
            nimp_next        = NUM_OF_IMP;
            num_samples_next = burst_len;
            start_calc_next  = 1'b1;
            state_next       = WAIT_RDY;
          end
        end
      end

      WAIT_RDY: begin
        if (ABORT) begin
          start_calc_next = 1'b0;
          state_next      = DONE;
        end else if (OUT_REG_READY) begin
          start_calc_next = 1'b0;
          phase_next      = '0;
          freq_next       = ftw_start_reg;
          samp_cnt_next   = '0;
          pulse_cnt_next  = '0;
          state_next      = PULSE;
        end
      end

      PULSE: begin
        rom_addr_next   = phase_reg[PHASE_W-1 -: ADDR_W];
        addr_valid_next = 1'b1;
        phase_next      = phase_reg + PHASE_W'(freq_reg);
        freq_next       = freq_stepped;
        samp_cnt_next   = samp_cnt_reg + CNT_W'(1);
        if (ABORT || (last_samp && last_pulse)) begin
          stop_calc_next = 1'b1;
          state_next     = DONE;
        end else if (last_samp) begin
          samp_cnt_next = '0;
          if (has_gap) begin
            state_next = GAP;
          end else begin
            // Back-to-back pulses: restart the chirp on the next cycle.
            phase_next     = '0;
            freq_next      = ftw_start_reg;
            pulse_cnt_next = pulse_cnt_reg + NIMP_W'(1);
          end
        end
      end

      GAP: begin
        addr_valid_next = 1'b1;
        samp_cnt_next   = samp_cnt_reg + CNT_W'(1);
        if (ABORT) begin
          stop_calc_next = 1'b1;
          state_next     = DONE;
        end else if (last_gap) begin
          phase_next     = '0;
          freq_next      = ftw_start_reg;
          samp_cnt_next  = '0;
          pulse_cnt_next = pulse_cnt_reg + NIMP_W'(1);
          state_next     = PULSE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs trail the state by one cycle, so BUSY must also stay high
    // for the cycle after DONE. It rises immediately on acceptance.
    busy_next = (state_reg != IDLE) || (state_next != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_reg       <= '0;
      freq_reg        <= '0;
      samp_cnt_reg    <= '0;
      pulse_cnt_reg   <= '0;
      mode_reg        <= '0;
      ftw_start_reg   <= '0;
      ftw_step_reg    <= '0;
      imp_reg         <= '0;
      period_reg      <= '0;
      nimp_reg        <= '0;
      rom_addr_reg    <= '0;
      addr_valid_reg  <= 1'b0;
      start_calc_reg  <= 1'b0;
      stop_calc_reg   <= 1'b0;
      num_samples_reg <= '0;
      busy_reg        <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      phase_reg       <= phase_next;
      freq_reg        <= freq_next;
      samp_cnt_reg    <= samp_cnt_next;
      pulse_cnt_reg   <= pulse_cnt_next;
      mode_reg        <= mode_next;
      ftw_start_reg   <= ftw_start_next;
      ftw_step_reg    <= ftw_step_next;
      imp_reg         <= imp_next;
      period_reg      <= period_next;
      nimp_reg        <= nimp_next;
      rom_addr_reg    <= rom_addr_next;
      addr_valid_reg  <= addr_valid_next;
      start_calc_reg  <= start_calc_next;
      stop_calc_reg   <= stop_calc_next;
      num_samples_reg <= num_samples_next;
      busy_reg        <= busy_next;
      cfg_err_reg     <= cfg_err_next;
    end
  end

  assign ROM_ADDRESS     = rom_addr_reg;
  assign ADDR_VALID      = addr_valid_reg;
  assign SIGN_START_CALC = start_calc_reg;
  assign SIGN_STOP_CALC  = stop_calc_reg;
  assign NUM_OF_SAMPLES  = num_samples_reg;
  assign BUSY            = busy_reg;
  assign CFG_ERR         = cfg_err_reg;

endmodule

// File: tb/tb_lfm_burst_phase_accum.sv
// -----------------------------------------------------------------------------
// tb_lfm_burst_phase_accum
//
// Directed bench for lfm_burst_phase_accum with hand-computed expectations.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge. Each scenario task drives the stimulus and makes its own comparisons.
// -----------------------------------------------------------------------------
module tb_lfm_burst_phase_accum;

  localparam int PHASE_W = 32;
  localparam int FREQ_W  = 32;
  localparam int ADDR_W  = 12;
  localparam int CNT_W   = 28;
  localparam int NIMP_W  = 5;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              SIGN_START_GEN;
  logic              ABORT;
  logic              OUT_REG_READY;
  logic [1:0]        MODE;
  logic [FREQ_W-1:0] FTW_START;
  logic [FREQ_W-1:0] FTW_STEP;
  logic [CNT_W-1:0]  IMP_SAMPLES;
  logic [CNT_W-1:0]  PERIOD_SAMPLES;
  logic [NIMP_W-1:0] NUM_OF_IMP;
  logic [ADDR_W-1:0] ROM_ADDRESS;
  logic              ADDR_VALID;
  logic              SIGN_START_CALC;
  logic              SIGN_STOP_CALC;
  logic [31:0]       NUM_OF_SAMPLES;
  logic              BUSY;
  logic              CFG_ERR;

  always #5 CLK = ~CLK;

  lfm_burst_phase_accum #(
    .PHASE_W(PHASE_W), .FREQ_W(FREQ_W), .ADDR_W(ADDR_W),
    .CNT_W(CNT_W), .NIMP_W(NIMP_W)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SIGN_START_GEN(SIGN_START_GEN),
    .ABORT(ABORT), .OUT_REG_READY(OUT_REG_READY), .MODE(MODE),
    .FTW_START(FTW_START), .FTW_STEP(FTW_STEP), .IMP_SAMPLES(IMP_SAMPLES),
    .PERIOD_SAMPLES(PERIOD_SAMPLES), .NUM_OF_IMP(NUM_OF_IMP),
    .ROM_ADDRESS(ROM_ADDRESS), .ADDR_VALID(ADDR_VALID),
    .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
    .NUM_OF_SAMPLES(NUM_OF_SAMPLES), .BUSY(BUSY), .CFG_ERR(CFG_ERR)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] cap_addr [0:63];
  logic              cap_stop [0:63];
  int                cap_n;
  bit                cap_timeout;

  // Drive a request for one cycle (caller sits just after a falling edge).
  // Afterwards, the configuration inputs are scrambled so that the bench can
  // show that only latched values matter.
  task automatic request(input logic [1:0] mode, input logic [31:0] fs,
                         input logic [31:0] step, input logic [27:0] imp,
                         input logic [27:0] per, input logic [4:0] n);
    MODE = mode; FTW_START = fs; FTW_STEP = step;
    IMP_SAMPLES = imp; PERIOD_SAMPLES = per; NUM_OF_IMP = n;
    SIGN_START_GEN = 1'b1;
    @(negedge CLK);
    SIGN_START_GEN = 1'b0;
    MODE = ~mode; FTW_START = 32'hDEAD_BEEF; FTW_STEP = 32'h0BAD_F00D;
    IMP_SAMPLES = 28'd1; PERIOD_SAMPLES = 28'd77; NUM_OF_IMP = 5'd9;
  endtask

  task automatic give_ready;
    OUT_REG_READY = 1'b1;
    @(negedge CLK);
    OUT_REG_READY = 1'b0;
  endtask

  // Record the run of valid samples and stop at the first invalid cycle.
  // When abort_at >= 0, ABORT is held for the state cycle that computes
  // sample number abort_at.
  task automatic capture(input int abort_at);
    bit started;
    started = 1'b0;
    cap_n = 0;
    cap_timeout = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cap_addr[i] = 'x;
      cap_stop[i] = 1'bx;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      if (ADDR_VALID === 1'b1) begin
        if (cap_n < 64) begin
          cap_addr[cap_n] = ROM_ADDRESS;
          cap_stop[cap_n] = SIGN_STOP_CALC;
        end
        cap_n++;
        started = 1'b1;
        ABORT = (cap_n == abort_at);
      end else if (started) begin
        cap_timeout = 1'b0;
        break;
      end
    end
    ABORT = 1'b0;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; SIGN_START_GEN = 1'b0; ABORT = 1'b0; OUT_REG_READY = 1'b0;
    MODE = '0; FTW_START = '0; FTW_STEP = '0;
    IMP_SAMPLES = '0; PERIOD_SAMPLES = '0; NUM_OF_IMP = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({ROM_ADDRESS, ADDR_VALID, SIGN_START_CALC, SIGN_STOP_CALC, BUSY, CFG_ERR} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0h v=%b sc=%b st=%b busy=%b err=%b, want all 0",
               ROM_ADDRESS, ADDR_VALID, SIGN_START_CALC, SIGN_STOP_CALC, BUSY, CFG_ERR);
    end
    checks++;
    if (NUM_OF_SAMPLES !== 32'd0) begin
      errors++; $display("FAIL reset_num_samples: got %0d want 0", NUM_OF_SAMPLES);
    end
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || ADDR_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy=%b valid=%b want 0 0", BUSY, ADDR_VALID);
    end
    $display("test_reset done");
  endtask

  task automatic test_cw;
    request(2'd0, 32'h1000_0000, 32'd0, 28'd8, 28'd8, 5'd1);
    checks++;
    if (SIGN_START_CALC !== 1'b1 || BUSY !== 1'b1 || ADDR_VALID !== 1'b0) begin
      errors++; $display("FAIL cw_accept: sc=%b busy=%b valid=%b want 1 1 0",
                         SIGN_START_CALC, BUSY, ADDR_VALID);
    end
    checks++;
    if (NUM_OF_SAMPLES !== 32'd8) begin
      errors++; $display("FAIL cw_num_samples: got %0d want 8", NUM_OF_SAMPLES);
    end
    give_ready;
    checks++;
    if (SIGN_START_CALC !== 1'b0 || ADDR_VALID !== 1'b0) begin
      errors++; $display("FAIL cw_ready_edge: sc=%b valid=%b want 0 0", SIGN_START_CALC, ADDR_VALID);
    end
    capture(-1);
    checks++;
    if (cap_timeout || cap_n != 8) begin
      errors++; $display("FAIL cw_count: got %0d timeout=%0d want 8", cap_n, cap_timeout);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_addr[i] !== 12'(i * 256) || cap_stop[i] !== (i == 7)) begin
        errors++; $display("FAIL cw_sample[%0d]: got addr=%0d stop=%b want addr=%0d stop=%b",
                           i, cap_addr[i], cap_stop[i], i * 256, (i == 7));
      end
    end
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL cw_busy_done: got %b want 1", BUSY);
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL cw_busy_fall: got %b want 0", BUSY);
    end
    $display("test_cw done: %0d samples", cap_n);
  endtask

  task automatic test_chirps;
    logic [1:0]  modes  [0:2] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] starts [0:2] = '{32'd0, 32'h0030_0000, 32'd0};
    int          exp [0:2][0:5] = '{'{0, 0, 1, 3, 6, 10},
                                    '{0, 3, 5, 6, 6, 5},
                                    '{0, 0, 1, 3, 6, 8}};
    for (int m = 0; m < 3; m++) begin
      request(modes[m], starts[m], 32'h0010_0000, 28'd6, 28'd6, 5'd1);
      give_ready;
      capture(-1);
      checks++;
      if (cap_timeout || cap_n != 6) begin
        errors++; $display("FAIL chirp_count mode %0d: got %0d want 6", modes[m], cap_n);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cap_addr[i] !== 12'(exp[m][i]) || cap_stop[i] !== (i == 5)) begin
          errors++; $display("FAIL chirp mode %0d sample[%0d]: got addr=%0d stop=%b want addr=%0d stop=%b",
                             modes[m], i, cap_addr[i], cap_stop[i], exp[m][i], (i == 5));
        end
      end
      @(negedge CLK);
      $display("test_chirps mode %0d done", modes[m]);
    end
  endtask

  task automatic test_burst;
    request(2'd0, 32'h1000_0000, 32'd0, 28'd4, 28'd6, 5'd3);
    checks++;
    if (NUM_OF_SAMPLES !== 32'd16) begin
      errors++; $display("FAIL burst_num_samples: got %0d want 16", NUM_OF_SAMPLES);
    end
    give_ready;
    capture(-1);
    checks++;
    if (cap_timeout || cap_n != 16) begin
      errors++; $display("FAIL burst_count: got %0d want 16", cap_n);
    end
    for (int i = 0; i < 16; i++) begin
      int e;
      e = ((i % 6) < 4) ? (i % 6) * 256 : 0;
      checks++;
      if (cap_addr[i] !== 12'(e) || cap_stop[i] !== (i == 15)) begin
        errors++; $display("FAIL burst_sample[%0d]: got addr=%0d stop=%b want addr=%0d stop=%b",
                           i, cap_addr[i], cap_stop[i], e, (i == 15));
      end
    end
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL burst_busy_done: got %b want 1", BUSY);
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL burst_busy_fall: got %b want 0", BUSY);
    end
    $display("test_burst done: %0d samples", cap_n);
  endtask

  task automatic test_back_to_back;
    // PERIOD == IMP: the pulses follow each other with no gap.
    request(2'd0, 32'h4000_0000, 32'd0, 28'd2, 28'd2, 5'd2);
    give_ready;
    capture(-1);
    checks++;
    if (cap_n != 4 || cap_addr[0] !== 12'd0 || cap_addr[1] !== 12'd1024 ||
        cap_addr[2] !== 12'd0 || cap_addr[3] !== 12'd1024 || cap_stop[3] !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got n=%0d %0d,%0d,%0d,%0d stop=%b want 4 0,1024,0,1024 1",
                         cap_n, cap_addr[0], cap_addr[1], cap_addr[2], cap_addr[3], cap_stop[3]);
    end
    // Issue the next request in the first IDLE cycle.
    request(2'd1, 32'd0, 32'h0010_0000, 28'd3, 28'd3, 5'd1);
    checks++;
    if (SIGN_START_CALC !== 1'b1 || BUSY !== 1'b1 || NUM_OF_SAMPLES !== 32'd3) begin
      errors++; $display("FAIL b2b_accept: sc=%b busy=%b num=%0d want 1 1 3",
                         SIGN_START_CALC, BUSY, NUM_OF_SAMPLES);
    end
    give_ready;
    capture(-1);
    checks++;
    if (cap_n != 3 || cap_addr[0] !== 12'd0 || cap_addr[1] !== 12'd0 || cap_addr[2] !== 12'd1) begin
      errors++; $display("FAIL b2b_second: got n=%0d %0d,%0d,%0d want 3 0,0,1",
                         cap_n, cap_addr[0], cap_addr[1], cap_addr[2]);
    end
    @(negedge CLK);
    $display("test_back_to_back done");
  endtask

  task automatic test_cfg_err;
    logic [27:0] imps [0:2] = '{28'd4, 28'd0, 28'd4};
    logic [27:0] pers [0:2] = '{28'd3, 28'd4, 28'd4};
    logic [4:0]  ns   [0:2] = '{5'd1, 5'd1, 5'd0};
    for (int k = 0; k < 3; k++) begin
      request(2'd0, 32'h1000_0000, 32'd0, imps[k], pers[k], ns[k]);
      checks++;
      if (CFG_ERR !== 1'b1 || SIGN_START_CALC !== 1'b0 || BUSY !== 1'b0 ||
          ADDR_VALID !== 1'b0 || NUM_OF_SAMPLES !== 32'd3) begin
        errors++; $display("FAIL cfg_err[%0d]: err=%b sc=%b busy=%b valid=%b num=%0d want 1 0 0 0 3",
                           k, CFG_ERR, SIGN_START_CALC, BUSY, ADDR_VALID, NUM_OF_SAMPLES);
      end
      @(negedge CLK);
      checks++;
      if (CFG_ERR !== 1'b0 || BUSY !== 1'b0 || SIGN_START_CALC !== 1'b0) begin
        errors++; $display("FAIL cfg_err_pulse[%0d]: err=%b busy=%b sc=%b want 0 0 0",
                           k, CFG_ERR, BUSY, SIGN_START_CALC);
      end
    end
    $display("test_cfg_err done");
  endtask

  task automatic test_wait_ready;
    int bad;
    bad = 0;
    request(2'd0, 32'h1000_0000, 32'd0, 28'd4, 28'd4, 5'd1);
    for (int k = 0; k < 10; k++) begin
      if (SIGN_START_CALC !== 1'b1 || ADDR_VALID !== 1'b0 || BUSY !== 1'b1) bad++;
      @(negedge CLK);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wait_ready_hold: got %0d bad cycles want 0", bad);
    end
    give_ready;
    capture(-1);
    checks++;
    if (cap_n != 4 || cap_addr[3] !== 12'd768 || cap_stop[3] !== 1'b1) begin
      errors++; $display("FAIL wait_ready_run: got n=%0d last=%0d stop=%b want 4 768 1",
                         cap_n, cap_addr[3], cap_stop[3]);
    end
    @(negedge CLK);
    $display("test_wait_ready done");
  endtask

  task automatic test_abort;
    int bad;
    request(2'd0, 32'h1000_0000, 32'd0, 28'd8, 28'd8, 5'd1);
    give_ready;
    capture(2);
    checks++;
    if (cap_timeout || cap_n != 3) begin
      errors++; $display("FAIL abort_count: got %0d want 3", cap_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_addr[i] !== 12'(i * 256) || cap_stop[i] !== (i == 2)) begin
        errors++; $display("FAIL abort_sample[%0d]: got addr=%0d stop=%b want addr=%0d stop=%b",
                           i, cap_addr[i], cap_stop[i], i * 256, (i == 2));
      end
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b want 0", BUSY);
    end
    // Abort while still waiting for ready: no samples at all.
    request(2'd0, 32'h1000_0000, 32'd0, 28'd4, 28'd4, 5'd1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    checks++;
    if (SIGN_START_CALC !== 1'b0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL abort_wait: sc=%b busy=%b want 0 1", SIGN_START_CALC, BUSY);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      OUT_REG_READY = 1'b1;
      if (ADDR_VALID !== 1'b0) bad++;
      @(negedge CLK);
    end
    OUT_REG_READY = 1'b0;
    checks++;
    if (bad != 0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL abort_wait_nosamples: got %0d valid cycles busy=%b want 0 0", bad, BUSY);
    end
    $display("test_abort done");
  endtask

  task automatic test_reset_mid_gap;
    request(2'd0, 32'h1000_0000, 32'd0, 28'd4, 28'd6, 5'd3);
    give_ready;
    repeat (5) @(negedge CLK);
    checks++;
    if (ADDR_VALID !== 1'b1 || ROM_ADDRESS !== 12'd0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL gap_before_reset: valid=%b addr=%0d busy=%b want 1 0 1",
                         ADDR_VALID, ROM_ADDRESS, BUSY);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({ROM_ADDRESS, ADDR_VALID, SIGN_START_CALC, SIGN_STOP_CALC, BUSY, CFG_ERR} !== '0 ||
        NUM_OF_SAMPLES !== 32'd0) begin
      errors++; $display("FAIL async_reset: addr=%0d v=%b sc=%b st=%b busy=%b err=%b num=%0d want all 0",
                         ROM_ADDRESS, ADDR_VALID, SIGN_START_CALC, SIGN_STOP_CALC, BUSY,
                         CFG_ERR, NUM_OF_SAMPLES);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (SIGN_STOP_CALC !== 1'b0 || BUSY !== 1'b0 || ADDR_VALID !== 1'b0) begin
      errors++; $display("FAIL after_reset_idle: stop=%b busy=%b valid=%b want 0 0 0",
                         SIGN_STOP_CALC, BUSY, ADDR_VALID);
    end
    request(2'd0, 32'h1000_0000, 32'd0, 28'd4, 28'd4, 5'd1);
    checks++;
    if (NUM_OF_SAMPLES !== 32'd4 || SIGN_START_CALC !== 1'b1) begin
      errors++; $display("FAIL after_reset_accept: num=%0d sc=%b want 4 1", NUM_OF_SAMPLES, SIGN_START_CALC);
    end
    give_ready;
    capture(-1);
    checks++;
    if (cap_n != 4 || cap_addr[0] !== 12'd0 || cap_addr[1] !== 12'd256 ||
        cap_addr[2] !== 12'd512 || cap_addr[3] !== 12'd768 || cap_stop[3] !== 1'b1) begin
      errors++; $display("FAIL after_reset_run: n=%0d %0d,%0d,%0d,%0d stop=%b want 4 0,256,512,768 1",
                         cap_n, cap_addr[0], cap_addr[1], cap_addr[2], cap_addr[3], cap_stop[3]);
    end
    @(negedge CLK);
    $display("test_reset_mid_gap done");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cw();
    test_chirps();
    test_burst();
    test_back_to_back();
    test_cfg_err();
    test_wait_ready();
    test_abort();
    test_reset_mid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
